// File: rtl/round_sat_pipe.sv
// Two-stage complex requantizer: rounds off FRAC_BITS fractional bits, then saturates or wraps to OUT_WIDTH.
// Carries a per-sample clip flag plus a sticky overflow flag and a saturating clip-event counter.
module round_sat_pipe #(
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned FRAC_BITS = 14,
  parameter int unsigned OUT_WIDTH = 16,
  parameter bit          SAT_EN    = 1'b1,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_in_ready,
  input  logic [IN_WIDTH-1:0]  i_real,
  input  logic [IN_WIDTH-1:0]  i_imag,
  input  logic [1:0]           i_mode,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [OUT_WIDTH-1:0] o_real,
  output logic [OUT_WIDTH-1:0] o_imag,
  output logic                 o_sat,
  input  logic                 i_ovf_clr,
  output logic                 o_ovf_sticky,
  output logic [CNT_WIDTH-1:0] o_sat_cnt
);

  localparam int unsigned RW = IN_WIDTH - FRAC_BITS + 1;
  localparam int unsigned EW = (OUT_WIDTH > RW) ? OUT_WIDTH : RW;
  localparam logic [OUT_WIDTH-1:0] MAX_V = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] MIN_V = {1'b1, {(OUT_WIDTH-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  // Floor plus a mode-dependent increment; q is one bit wider so q+inc never overflows.
  function automatic logic [RW-1:0] round_comp(input logic [IN_WIDTH-1:0] x,
                                               input logic [1:0] mode);
    logic [RW-1:0] q;
    logic          h;
    logic          s;
    logic          inc;
    q = {x[IN_WIDTH-1], x[IN_WIDTH-1:FRAC_BITS]};
    h = x[FRAC_BITS-1];
    s = |x[FRAC_BITS-2:0];
    case (mode)
      2'd0:    inc = 1'b0;
      2'd2:    inc = h & (s | q[0]);
      default: inc = h & (s | ~x[IN_WIDTH-1]);
    endcase
    return q + RW'(inc);
  endfunction

  // Returns {clipped, value}; a wrapped out-of-range value still reports clipped.
  function automatic logic [OUT_WIDTH:0] requant(input logic [RW-1:0] r);
    logic [EW-1:0] rx;
    logic          fits;
    rx   = EW'($signed(r));
    fits = (rx[EW-1:OUT_WIDTH-1] == '0) || (rx[EW-1:OUT_WIDTH-1] == '1);
    if (fits || !SAT_EN) begin
      return {~fits, rx[OUT_WIDTH-1:0]};
    end
    return {1'b1, (rx[EW-1] ? MIN_V : MAX_V)};
  endfunction

  logic                 en;
  logic                 hs_sat;
  logic                 re_clip, im_clip;
  logic [OUT_WIDTH-1:0] re_val, im_val;

  logic                 valid_s1_q, valid_s1_d;
  logic [RW-1:0]        r_re_q, r_re_d;
  logic [RW-1:0]        r_im_q, r_im_d;
  logic                 valid_q, valid_d;
  logic [OUT_WIDTH-1:0] out_re_q, out_re_d;
  logic [OUT_WIDTH-1:0] out_im_q, out_im_d;
  logic                 sat_q, sat_d;
  logic                 sticky_q, sticky_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Pipeline advance, stage-2 requantization and flag bookkeeping.
  always_comb begin
    en         = ~valid_q | i_ready;
    hs_sat     = valid_q & i_ready & sat_q;
    {re_clip, re_val} = requant(r_re_q);
    {im_clip, im_val} = requant(r_im_q);

    valid_s1_d = valid_s1_q;
    r_re_d     = r_re_q;
    r_im_d     = r_im_q;
    valid_d    = valid_q;
    out_re_d   = out_re_q;
    out_im_d   = out_im_q;
    sat_d      = sat_q;
    sticky_d   = sticky_q;
    cnt_d      = cnt_q;

    if (en) begin
      valid_s1_d = i_valid;
      r_re_d     = round_comp(i_real, i_mode);
      r_im_d     = round_comp(i_imag, i_mode);
      valid_d    = valid_s1_q;
      out_re_d   = re_val;
      out_im_d   = im_val;
      sat_d      = valid_s1_q & (re_clip | im_clip);
    end

    // Clear takes effect first, then a coincident clipped handshake is still counted.
    if (i_ovf_clr) begin
      sticky_d = hs_sat;
      cnt_d    = hs_sat ? CNT_WIDTH'(1) : '0;
    end else if (hs_sat) begin
      sticky_d = 1'b1;
      cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_s1_q <= 1'b0;
      r_re_q     <= '0;
      r_im_q     <= '0;
      valid_q    <= 1'b0;
      out_re_q   <= '0;
      out_im_q   <= '0;
      sat_q      <= 1'b0;
      sticky_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      valid_s1_q <= valid_s1_d;
      r_re_q     <= r_re_d;
      r_im_q     <= r_im_d;
      valid_q    <= valid_d;
      out_re_q   <= out_re_d;
      out_im_q   <= out_im_d;
      sat_q      <= sat_d;
      sticky_q   <= sticky_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_in_ready   = en;
  assign o_valid      = valid_q;
  assign o_real       = out_re_q;
  assign o_imag       = out_im_q;
  assign o_sat        = sat_q;
  assign o_ovf_sticky = sticky_q;
  assign o_sat_cnt    = cnt_q;

endmodule

// File: tb/tb_round_sat_pipe.sv
// Directed bench for round_sat_pipe: default instance plus two narrow-output instances (saturate / wrap).
module tb_round_sat_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, ready, ovf_clr;
  logic [15:0] in_re, in_im;
  logic [1:0]  mode;

  logic        a_in_ready, a_valid, a_sat, a_sticky;
  logic [15:0] a_re, a_im, a_cnt;
  logic        b_in_ready, b_valid, b_sat, b_sticky;
  logic [1:0]  b_re, b_im, b_cnt;
  logic        c_in_ready, c_valid, c_sat, c_sticky;
  logic [1:0]  c_re, c_im, c_cnt;

  int errors = 0;
  int checks = 0;

  round_sat_pipe u_a (
    .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_in_ready(a_in_ready),
    .i_real(in_re), .i_imag(in_im), .i_mode(mode), .o_valid(a_valid), .i_ready(ready),
    .o_real(a_re), .o_imag(a_im), .o_sat(a_sat), .i_ovf_clr(ovf_clr),
    .o_ovf_sticky(a_sticky), .o_sat_cnt(a_cnt)
  );

  round_sat_pipe #(.OUT_WIDTH(2), .SAT_EN(1'b1), .CNT_WIDTH(2)) u_b (
    .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_in_ready(b_in_ready),
    .i_real(in_re), .i_imag(in_im), .i_mode(mode), .o_valid(b_valid), .i_ready(ready),
    .o_real(b_re), .o_imag(b_im), .o_sat(b_sat), .i_ovf_clr(ovf_clr),
    .o_ovf_sticky(b_sticky), .o_sat_cnt(b_cnt)
  );

  round_sat_pipe #(.OUT_WIDTH(2), .SAT_EN(1'b0), .CNT_WIDTH(2)) u_c (
    .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_in_ready(c_in_ready),
    .i_real(in_re), .i_imag(in_im), .i_mode(mode), .o_valid(c_valid), .i_ready(ready),
    .o_real(c_re), .o_imag(c_im), .o_sat(c_sat), .i_ovf_clr(ovf_clr),
    .o_ovf_sticky(c_sticky), .o_sat_cnt(c_cnt)
  );

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; ovf_clr = 1'b0; ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One sample through an unstalled pipe; returns once it sits at the output.
  task automatic push(input logic [15:0] re, input logic [15:0] im, input logic [1:0] m);
    in_re = re; in_im = im; mode = m; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (a_valid !== 1'b0 || b_valid !== 1'b0 || c_valid !== 1'b0)
      begin errors++; $display("FAIL reset_valid: got %b%b%b expected 000", a_valid, b_valid, c_valid); end
    checks++;
    if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1 || c_in_ready !== 1'b1)
      begin errors++; $display("FAIL reset_in_ready: got %b%b%b expected 111", a_in_ready, b_in_ready, c_in_ready); end
    checks++;
    if (a_re !== 16'h0 || a_im !== 16'h0 || a_sat !== 1'b0)
      begin errors++; $display("FAIL reset_data: got %h %h %b expected 0000 0000 0", a_re, a_im, a_sat); end
    checks++;
    if (a_sticky !== 1'b0 || a_cnt !== 16'h0)
      begin errors++; $display("FAIL reset_flags: got %b %h expected 0 0000", a_sticky, a_cnt); end
  endtask

  task automatic test_modes();
    logic [15:0] exp_re [3];
    logic [15:0] exp_im [3];
    exp_re = '{16'h0000, 16'h0001, 16'h0000};
    exp_im = '{16'hFFFF, 16'hFFFF, 16'h0000};
    for (int m = 0; m < 3; m++) begin
      in_re = 16'h2000; in_im = 16'hE000; mode = 2'(m); in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if (a_valid !== 1'b0)
        begin errors++; $display("FAIL mode%0d_latency: o_valid=%b one cycle after accept, expected 0", m, a_valid); end
      @(posedge clk); #1;
      checks++;
      if (a_valid !== 1'b1 || a_re !== exp_re[m] || a_im !== exp_im[m] || a_sat !== 1'b0)
        begin errors++; $display("FAIL mode%0d_half: got v=%b %h %h sat=%b expected v=1 %h %h sat=0",
                                 m, a_valid, a_re, a_im, a_sat, exp_re[m], exp_im[m]); end
    end
  endtask

  task automatic test_ties();
    push(16'h6000, 16'hA000, 2'd2);
    checks++;
    if (a_re !== 16'h0002 || a_im !== 16'hFFFE)
      begin errors++; $display("FAIL conv_1p5: got %h %h expected 0002 fffe", a_re, a_im); end
    push(16'h6001, 16'hDFFF, 2'd1);
    checks++;
    if (a_re !== 16'h0002 || a_im !== 16'hFFFF)
      begin errors++; $display("FAIL away_near_tie: got %h %h expected 0002 ffff", a_re, a_im); end
    push(16'h2000, 16'hE000, 2'd3);
    checks++;
    if (a_re !== 16'h0001 || a_im !== 16'hFFFF)
      begin errors++; $display("FAIL mode3_as_1: got %h %h expected 0001 ffff", a_re, a_im); end
  endtask

  task automatic test_mode_switch();
    in_re = 16'h2000; in_im = 16'h2000; mode = 2'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    mode = 2'd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (a_valid !== 1'b1 || a_re !== 16'h0000 || a_im !== 16'h0000)
      begin errors++; $display("FAIL switch_first: got v=%b %h %h expected v=1 0000 0000", a_valid, a_re, a_im); end
    @(posedge clk); #1;
    checks++;
    if (a_valid !== 1'b1 || a_re !== 16'h0001 || a_im !== 16'h0001)
      begin errors++; $display("FAIL switch_second: got v=%b %h %h expected v=1 0001 0001", a_valid, a_re, a_im); end
  endtask

  task automatic test_sat();
    do_reset();
    push(16'h7FFF, 16'h0000, 2'd1);
    checks++;
    if (b_re !== 2'b01 || b_im !== 2'b00 || b_sat !== 1'b1)
      begin errors++; $display("FAIL sat_clip: got %b %b sat=%b expected 01 00 sat=1", b_re, b_im, b_sat); end
    checks++;
    if (c_re !== 2'b10 || c_im !== 2'b00 || c_sat !== 1'b1)
      begin errors++; $display("FAIL sat_wrap: got %b %b sat=%b expected 10 00 sat=1", c_re, c_im, c_sat); end
    checks++;
    if (b_sticky !== 1'b0 || b_cnt !== 2'd0)
      begin errors++; $display("FAIL sat_before_hs: got sticky=%b cnt=%0d expected 0 0", b_sticky, b_cnt); end
    @(posedge clk); #1;
    checks++;
    if (b_sticky !== 1'b1 || b_cnt !== 2'd1 || c_sticky !== 1'b1 || c_cnt !== 2'd1)
      begin errors++; $display("FAIL sat_flags: got b=%b/%0d c=%b/%0d expected 1/1 1/1", b_sticky, b_cnt, c_sticky, c_cnt); end
    push(16'h4000, 16'h0000, 2'd0);
    @(posedge clk); #1;
    checks++;
    if (b_sat !== 1'b0 || b_cnt !== 2'd1)
      begin errors++; $display("FAIL sat_fits: got sat=%b cnt=%0d expected sat=0 cnt=1", b_sat, b_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] er [8];
    logic [15:0] ei [8];
    logic [15:0] held_re, held_im;
    logic        prev_stall;
    int          in_idx, out_idx;
    er = '{16'h0000, 16'h0001, 16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'hFFFE, 16'hFFFF};
    ei = '{16'h0000, 16'h0001, 16'h0001, 16'h0002, 16'hFFFE, 16'hFFFE, 16'hFFFF, 16'hFFFF};
    in_valid = 1'b0; ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    in_idx = 0; out_idx = 0; prev_stall = 1'b0; held_re = '0; held_im = '0;
    for (int cyc = 0; cyc < 80 && out_idx < 8; cyc++) begin
      ready    = (cyc % 4 == 0) || (cyc % 4 == 3);
      in_valid = (in_idx < 8);
      in_re    = 16'(in_idx << 14);
      in_im    = 16'(in_idx << 13);
      mode     = 2'd1;
      #2;
      if (prev_stall) begin
        checks++;
        if (a_valid !== 1'b1 || a_re !== held_re || a_im !== held_im)
          begin errors++; $display("FAIL stall_hold: got v=%b %h %h expected v=1 %h %h", a_valid, a_re, a_im, held_re, held_im); end
      end
      checks++;
      if (a_valid && !ready) begin
        if (a_in_ready !== 1'b0)
          begin errors++; $display("FAIL stall_in_ready: got %b expected 0", a_in_ready); end
        prev_stall = 1'b1; held_re = a_re; held_im = a_im;
      end else begin
        if (a_in_ready !== 1'b1)
          begin errors++; $display("FAIL flow_in_ready: got %b expected 1", a_in_ready); end
        prev_stall = 1'b0;
      end
      if (a_valid && ready) begin
        checks++;
        if (a_re !== er[out_idx] || a_im !== ei[out_idx])
          begin errors++; $display("FAIL stream_%0d: got %h %h expected %h %h", out_idx, a_re, a_im, er[out_idx], ei[out_idx]); end
        out_idx++;
      end
      if (in_valid && a_in_ready) in_idx++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; ready = 1'b1;
    checks++;
    if (out_idx != 8 || in_idx != 8)
      begin errors++; $display("FAIL stream_count: got out=%0d in=%0d expected 8 8", out_idx, in_idx); end
  endtask

  task automatic test_counter();
    do_reset();
    in_re = 16'h7FFF; in_im = 16'h0000; mode = 2'd1; in_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (b_cnt !== 2'd3 || b_sticky !== 1'b1)
      begin errors++; $display("FAIL cnt_saturate: got cnt=%0d sticky=%b expected 3 1", b_cnt, b_sticky); end
    checks++;
    if (a_cnt !== 16'h0 || a_sticky !== 1'b0)
      begin errors++; $display("FAIL cnt_noclip: got cnt=%0d sticky=%b expected 0 0", a_cnt, a_sticky); end
    push(16'h7FFF, 16'h0000, 2'd1);
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    checks++;
    if (b_cnt !== 2'd1 || b_sticky !== 1'b1)
      begin errors++; $display("FAIL clr_with_event: got cnt=%0d sticky=%b expected 1 1", b_cnt, b_sticky); end
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    checks++;
    if (b_cnt !== 2'd0 || b_sticky !== 1'b0)
      begin errors++; $display("FAIL clr_alone: got cnt=%0d sticky=%b expected 0 0", b_cnt, b_sticky); end
  endtask

  task automatic test_reset_flush();
    logic seen;
    push(16'h7FFF, 16'h0000, 2'd1);
    @(posedge clk); #1;
    checks++;
    if (b_cnt !== 2'd1)
      begin errors++; $display("FAIL flush_pre_cnt: got %0d expected 1", b_cnt); end
    in_re = 16'h4000; in_im = 16'h0000; mode = 2'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_re = 16'h7FFF; mode = 2'd1;
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (a_valid !== 1'b0 || a_re !== 16'h0 || a_in_ready !== 1'b1)
      begin errors++; $display("FAIL flush_out: got v=%b re=%h rdy=%b expected 0 0000 1", a_valid, a_re, a_in_ready); end
    checks++;
    if (b_cnt !== 2'd0 || b_sticky !== 1'b0 || b_sat !== 1'b0)
      begin errors++; $display("FAIL flush_flags: got cnt=%0d sticky=%b sat=%b expected 0 0 0", b_cnt, b_sticky, b_sat); end
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      seen = seen | a_valid | b_valid;
    end
    checks++;
    if (seen !== 1'b0)
      begin errors++; $display("FAIL flush_reappear: got o_valid seen=%b expected 0", seen); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; ready = 1'b1; ovf_clr = 1'b0;
    in_re = '0; in_im = '0; mode = '0;
    test_reset();
    test_modes();
    test_ties();
    test_mode_switch();
    test_sat();
    test_back_to_back();
    test_counter();
    test_reset_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
